// File: rtl/delay_tap_reader.sv
// Echo-buffer read tap: fetches the sample delay_len behind wr_ptr, scales it by wet_gain, adds dry.
// Build option: define DELAY_TAP_SAT_EN to clamp the mix to 16 bits instead of wrapping.
`timescale 1ns/1ps
module delay_tap_reader #(
  parameter int DEPTH  = 48000,
  parameter int ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              sample_tick,
  input  logic [15:0]       dry_in,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [15:0]       wet_gain,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic [15:0]       mem_rd_data,
  output logic [15:0]       out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun,
  output logic [1:0]        dbg_state_o
);

  // Handshake: mem_rd_req rises the cycle after an accepted tick and holds with a stable
  // mem_rd_addr; the first cycle with mem_rd_ack=1 transfers mem_rd_data and ends the request.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_MIX  = 2'd2,
    S_PASS = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_M1 = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  state_t              state_q, state_d;
  logic signed [15:0]  dry_q, gain_q, data_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   eff_delay;
  logic [15:0]         out_q, mix_d;
  logic                out_valid_q;
  logic                overrun_q;
  logic                accept;

  logic signed [31:0]  prod;
  logic signed [16:0]  wet;
  logic signed [17:0]  sum;

  assign accept = sample_tick && (state_q == S_IDLE);

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sample_tick) state_d = Enable ? S_REQ : S_PASS;
      S_REQ:   if (mem_rd_ack)  state_d = S_MIX;
      S_MIX:   state_d = S_IDLE;
      S_PASS:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_rd_req  = (state_q == S_REQ);
    busy        = (state_q != S_IDLE);
    dbg_state_o = state_q;
  end

  // Delay is clamped into 1..DEPTH-1 so the tap never reads the sample being written.
  always_comb begin
    eff_delay = delay_len;
    if (delay_len == '0)           eff_delay = ONE_A;
    else if (delay_len >= DEPTH_A) eff_delay = DEPTH_M1;
    if (wr_ptr >= eff_delay) addr_d = wr_ptr - eff_delay;
    else                     addr_d = wr_ptr + (DEPTH_A - eff_delay);
  end

  always_comb begin
    prod = gain_q * data_q;
    wet  = prod[31:15];
    sum  = {{2{dry_q[15]}}, dry_q} + {wet[16], wet};
  end

  logic unused_prod_lsbs;
  assign unused_prod_lsbs = ^prod[14:0];

`ifdef DELAY_TAP_SAT_EN
  always_comb begin
    if (sum > 18'sd32767)       mix_d = 16'h7FFF;
    else if (sum < -18'sd32768) mix_d = 16'h8000;
    else                        mix_d = sum[15:0];
  end
`else
  logic unused_sum_msbs;
  assign unused_sum_msbs = ^sum[17:16];
  always_comb mix_d = sum[15:0];
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      dry_q       <= '0;
      gain_q      <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        dry_q  <= dry_in;
        gain_q <= wet_gain;
        addr_q <= addr_d;
      end
      if (state_q == S_REQ && mem_rd_ack) data_q <= mem_rd_data;
      if (state_q == S_MIX) begin
        out_q       <= mix_d;
        out_valid_q <= 1'b1;
      end
      if (state_q == S_PASS) begin
        out_q       <= dry_q;
        out_valid_q <= 1'b1;
      end
      if (sample_tick && state_q != S_IDLE) overrun_q <= 1'b1;
    end
  end

  assign mem_rd_addr = addr_q;
  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_delay_tap_reader.sv
// Directed bench for delay_tap_reader: address wrap, mix arithmetic, passthrough, overrun, reset.
`timescale 1ns/1ps
module tb_delay_tap_reader;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic        sample_tick;
  logic [15:0] dry_in;
  logic [15:0] wr_ptr;
  logic [15:0] delay_len;
  logic [15:0] wet_gain;
  logic        mem_rd_req;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_ack;
  logic [15:0] mem_rd_data;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;
  logic        overrun;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  delay_tap_reader #(.DEPTH(48000), .ADDR_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .sample_tick(sample_tick),
    .dry_in(dry_in), .wr_ptr(wr_ptr), .delay_len(delay_len), .wet_gain(wet_gain),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_data(mem_rd_data), .out(out), .out_valid(out_valid), .busy(busy),
    .overrun(overrun), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge Clk);
    #1;
  endtask

  // Tick at cycle 0, ack at cycle k; result expected at cycle k+2.
  task automatic run_mix(input string tag, input logic [15:0] dry, input logic [15:0] data,
                         input logic [15:0] wet, input logic [15:0] wr, input logic [15:0] dl,
                         input int k, input logic [15:0] exp_addr, input logic [15:0] exp_out);
    Enable = 1'b1; dry_in = dry; wet_gain = wet; wr_ptr = wr; delay_len = dl;
    sample_tick = 1'b1;
    for (int c = 1; c <= k; c++) begin
      next_cyc();
      if (c == 1) begin
        sample_tick = 1'b0;
        Enable = 1'b0; dry_in = 16'h0BAD; wet_gain = 16'h0; wr_ptr = 16'd7; delay_len = 16'd3;
        check({tag, "_req"}, mem_rd_req, 1);
        check({tag, "_addr"}, mem_rd_addr, exp_addr);
      end
      if (c == k) begin
        mem_rd_ack = 1'b1;
        mem_rd_data = data;
      end
    end
    next_cyc();
    mem_rd_ack = 1'b0; mem_rd_data = 16'hDEAD;
    check({tag, "_req_drop"}, mem_rd_req, 0);
    check({tag, "_vld_early"}, out_valid, 0);
    next_cyc();
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_out"}, out, exp_out);
    check({tag, "_busy"}, busy, 0);
  endtask

  // expected-value table for build-dependent results
  logic [15:0] exp_ovf, exp_ext, exp_neg;
  int vcount;

  initial begin
`ifdef DELAY_TAP_SAT_EN
    exp_ovf = 16'h7FFF; exp_ext = 16'h7FFF; exp_neg = 16'h8000;
`else
    exp_ovf = 16'hAFFF; exp_ext = 16'h8000; exp_neg = 16'h4000;
`endif
    Reset = 1'b0; Enable = 1'b0; sample_tick = 1'b0; dry_in = '0; wr_ptr = '0;
    delay_len = '0; wet_gain = '0; mem_rd_ack = 1'b0; mem_rd_data = 16'hDEAD;
    repeat (3) next_cyc();
    check("rst_out", out, 0);
    check("rst_vld", out_valid, 0);
    check("rst_req", mem_rd_req, 0);
    check("rst_addr", mem_rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    Reset = 1'b1;
    next_cyc();

    // mix paths
    run_mix("wrap", 16'h1000, 16'h4000, 16'h4000, 16'd5, 16'd10, 3, 16'd47995, 16'h3000);
    run_mix("ovf", 16'h7000, 16'h4000, 16'h7FFF, 16'd100, 16'd0, 1, 16'd99, exp_ovf);
    run_mix("ext", 16'h0000, 16'h8000, 16'h8000, 16'd0, 16'd0, 1, 16'd47999, exp_ext);
    run_mix("neg", 16'hF000, 16'hC000, 16'h4000, 16'd100, 16'd60000, 2, 16'd101, 16'hD000);
    run_mix("negc", 16'h8000, 16'h4000, 16'h8000, 16'd47999, 16'd47999, 1, 16'd0, exp_neg);
    next_cyc();

    // passthrough, then a tick in the out_valid cycle
    Enable = 1'b0; dry_in = 16'h1234; sample_tick = 1'b1;
    next_cyc();
    sample_tick = 1'b0; dry_in = 16'h0000;
    check("pass_busy", busy, 1);
    check("pass_req1", mem_rd_req, 0);
    next_cyc();
    check("pass_vld", out_valid, 1);
    check("pass_out", out, 16'h1234);
    check("pass_req2", mem_rd_req, 0);
    dry_in = 16'h5678; sample_tick = 1'b1;
    next_cyc();
    sample_tick = 1'b0;
    check("coin_busy", busy, 1);
    next_cyc();
    check("coin_out", out, 16'h5678);
    check("coin_ovr", overrun, 0);
    next_cyc();

    // overrun: second tick at cycle 4, ack at cycle 8
    Enable = 1'b1; dry_in = 16'h0000; wet_gain = 16'h4000; wr_ptr = 16'd5; delay_len = 16'd10;
    sample_tick = 1'b1;
    vcount = 0;
    for (int c = 1; c <= 14; c++) begin
      next_cyc();
      if (out_valid) vcount++;
      if (c == 1) check("ovr_init", overrun, 0);
      if (c == 5) begin
        check("ovr_set", overrun, 1);
        check("ovr_addr", mem_rd_addr, 16'd47995);
      end
      if (c == 10) check("ovr_out", out, 16'h1000);
      sample_tick = (c == 4);
      if (c == 4) begin wr_ptr = 16'd200; dry_in = 16'h7777; end
      mem_rd_ack = (c == 8);
      mem_rd_data = (c == 8) ? 16'h2000 : 16'hDEAD;
    end
    check("ovr_vcount", vcount, 1);

    // reset mid-request
    wr_ptr = 16'd5; sample_tick = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cyc();
      sample_tick = 1'b0;
    end
    check("mid_req", mem_rd_req, 1);
    #3 Reset = 1'b0;
    #1;
    check("arst_req", mem_rd_req, 0);
    check("arst_out", out, 0);
    check("arst_ovr", overrun, 0);
    check("arst_busy", busy, 0);
    #2 Reset = 1'b1;
    next_cyc();

    // resume after reset
    Enable = 1'b0; dry_in = 16'h0042; sample_tick = 1'b1;
    next_cyc();
    sample_tick = 1'b0;
    next_cyc();
    check("resume_out", out, 16'h0042);
    check("resume_vld", out_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
